// File: rtl/event_rr_arbiter2.sv
// Two-input round-robin event merger with one-entry holding slots and a
// post-issue holdoff so a registered downstream request never double-issues.
module event_rr_arbiter2 #(
    parameter int DATA_WIDTH = 4,
    parameter int REQ_GAP    = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_event_value_0,
    input  logic [15:0]           in_event_addr_0,
    input  logic                  in_event_valid_0,
    output logic                  out_event_req_0,
    input  logic [DATA_WIDTH-1:0] in_event_value_1,
    input  logic [15:0]           in_event_addr_1,
    input  logic                  in_event_valid_1,
    output logic                  out_event_req_1,
    input  logic                  ready_for_new_event,
    output logic [DATA_WIDTH-1:0] out_event_value,
    output logic [15:0]           out_event_addr,
    output logic                  out_event_src,
    output logic                  out_event_valid,
    output logic                  overflow_0,
    output logic                  overflow_1,
    output logic [CNT_WIDTH-1:0]  issued_cnt_0,
    output logic [CNT_WIDTH-1:0]  issued_cnt_1,
    output logic                  idle
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_HOLDOFF = 1'b1
    } state_t;

    localparam logic [3:0] GAP = 4'(REQ_GAP);

    state_t                state_q, state_d;
    logic [3:0]            hold_q, hold_d;
    logic                  rr_q, rr_d;
    logic                  full0_q, full0_d, full1_q, full1_d;
    logic [DATA_WIDTH-1:0] val0_q, val0_d, val1_q, val1_d;
    logic [15:0]           addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DATA_WIDTH-1:0] oval_q, oval_d;
    logic [15:0]           oaddr_q, oaddr_d;
    logic                  osrc_q, osrc_d;
    logic                  ovld_q, ovld_d;
    logic                  ovf0_q, ovf0_d, ovf1_q, ovf1_d;
    logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic issue, sel, iss0, iss1;

    always_comb begin
        issue = (state_q == S_IDLE) && ready_for_new_event && (full0_q || full1_q);
        // With one slot full it wins outright; rr_q only breaks ties.
        sel   = (full0_q && full1_q) ? rr_q : full1_q;
        iss0  = issue && !sel;
        iss1  = issue && sel;

        state_d = state_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        full0_d = full0_q;
        full1_d = full1_q;
        val0_d  = val0_q;
        val1_d  = val1_q;
        addr0_d = addr0_q;
        addr1_d = addr1_q;
        oval_d  = oval_q;
        oaddr_d = oaddr_q;
        osrc_d  = osrc_q;
        ovld_d  = 1'b0;
        ovf0_d  = ovf0_q;
        ovf1_d  = ovf1_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;

        // A strobe into a slot being drained this cycle refills it directly.
        if (in_event_valid_0 && (!full0_q || iss0)) begin
            full0_d = 1'b1;
            val0_d  = in_event_value_0;
            addr0_d = in_event_addr_0;
        end else if (iss0) begin
            full0_d = 1'b0;
        end
        if (in_event_valid_0 && full0_q && !iss0) ovf0_d = 1'b1;

        if (in_event_valid_1 && (!full1_q || iss1)) begin
            full1_d = 1'b1;
            val1_d  = in_event_value_1;
            addr1_d = in_event_addr_1;
        end else if (iss1) begin
            full1_d = 1'b0;
        end
        if (in_event_valid_1 && full1_q && !iss1) ovf1_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    ovld_d  = 1'b1;
                    oval_d  = sel ? val1_q : val0_q;
                    oaddr_d = sel ? addr1_q : addr0_q;
                    osrc_d  = sel;
                    rr_d    = !sel;
                    if (iss0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
                    if (iss1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
                    hold_d  = GAP;
                    state_d = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (hold_q <= 4'd1) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            rr_q    <= 1'b0;
            full0_q <= 1'b0;
            full1_q <= 1'b0;
            val0_q  <= '0;
            val1_q  <= '0;
            addr0_q <= '0;
            addr1_q <= '0;
            oval_q  <= '0;
            oaddr_q <= '0;
            osrc_q  <= 1'b0;
            ovld_q  <= 1'b0;
            ovf0_q  <= 1'b0;
            ovf1_q  <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
            full0_q <= full0_d;
            full1_q <= full1_d;
            val0_q  <= val0_d;
            val1_q  <= val1_d;
            addr0_q <= addr0_d;
            addr1_q <= addr1_d;
            oval_q  <= oval_d;
            oaddr_q <= oaddr_d;
            osrc_q  <= osrc_d;
            ovld_q  <= ovld_d;
            ovf0_q  <= ovf0_d;
            ovf1_q  <= ovf1_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign out_event_req_0 = !full0_q;
    assign out_event_req_1 = !full1_q;
    assign out_event_value = oval_q;
    assign out_event_addr  = oaddr_q;
    assign out_event_src   = osrc_q;
    assign out_event_valid = ovld_q;
    assign overflow_0      = ovf0_q;
    assign overflow_1      = ovf1_q;
    assign issued_cnt_0    = cnt0_q;
    assign issued_cnt_1    = cnt1_q;
    assign idle            = !full0_q && !full1_q && (state_q == S_IDLE);

endmodule

// File: tb/tb_event_rr_arbiter2.sv
// Directed-vector bench for event_rr_arbiter2; expected events queue into a
// scoreboard that a negedge monitor drains whenever out_event_valid is seen.
module tb_event_rr_arbiter2;

    localparam int DW  = 4;
    localparam int GAP = 2;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] v0 = '0, v1 = '0;
    logic [15:0]   a0 = '0, a1 = '0;
    logic          s0 = 1'b0, s1 = 1'b0;
    logic          ready = 1'b0;
    logic          req0, req1;
    logic [DW-1:0] o_val;
    logic [15:0]   o_addr;
    logic          o_src, o_vld;
    logic          ovf0, ovf1;
    logic [CW-1:0] cnt0, cnt1;
    logic          idle;

    event_rr_arbiter2 #(.DATA_WIDTH(DW), .REQ_GAP(GAP), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_event_value_0(v0), .in_event_addr_0(a0), .in_event_valid_0(s0),
        .out_event_req_0(req0),
        .in_event_value_1(v1), .in_event_addr_1(a1), .in_event_valid_1(s1),
        .out_event_req_1(req1),
        .ready_for_new_event(ready),
        .out_event_value(o_val), .out_event_addr(o_addr), .out_event_src(o_src),
        .out_event_valid(o_vld),
        .overflow_0(ovf0), .overflow_1(ovf1),
        .issued_cnt_0(cnt0), .issued_cnt_1(cnt1),
        .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          src;
        logic [15:0]   addr;
        logic [DW-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   issue_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_issue = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) last_issue = -1;
        if (o_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got src %0d addr 0x%0h with no event expected (cycle %0d)",
                         o_src, o_addr, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("out_src",   32'(o_src),  32'(e.src));
                chk("out_addr",  32'(o_addr), 32'(e.addr));
                chk("out_value", 32'(o_val),  32'(e.val));
            end
            if (last_issue >= 0)
                chk("issue_spacing_ok", 32'(cyc - last_issue >= GAP + 1), 32'd1);
            last_issue = cyc;
            issue_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic exp_t mk(input logic src, input logic [15:0] addr, input logic [DW-1:0] val);
        exp_t e;
        e.src  = src;
        e.addr = addr;
        e.val  = val;
        return e;
    endfunction

    task automatic chk_spacing(input string name, input int n);
        chk({name, "_count"}, 32'(issue_cyc.size()), 32'(n));
        for (int i = 1; i < issue_cyc.size(); i++)
            chk(name, 32'(issue_cyc[i] - issue_cyc[i-1]), 32'(GAP + 1));
    endtask

    initial begin
        int  bad;
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_req0", 32'(req0), 32'd1);
        chk("rst_req1", 32'(req1), 32'd1);
        chk("rst_valid", 32'(o_vld), 32'd0);
        chk("rst_out_addr", 32'(o_addr), 32'd0);
        chk("rst_out_value", 32'(o_val), 32'd0);
        chk("rst_out_src", 32'(o_src), 32'd0);
        chk("rst_ovf0", 32'(ovf0), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);

        // Single-source flow
        ready = 1'b1;
        #1;
        s0 = 1'b1; a0 = 16'h0102; v0 = 4'd5;
        exp_q.push_back(mk(1'b0, 16'h0102, 4'd5));
        tick();
        s0 = 1'b0;
        @(negedge clk);
        chk("single_no_valid_at_capture", 32'(o_vld), 32'd0);
        chk("single_req0_low_when_full", 32'(req0), 32'd0);
        tick();
        @(negedge clk);
        chk("single_valid_next_cycle", 32'(o_vld), 32'd1);
        repeat (5) tick();
        chk("single_cnt0", 32'(cnt0), 32'd1);
        chk("single_idle", 32'(idle), 32'd1);

        // Round-robin from reset pointer
        do_reset();
        issue_cyc.delete();
        s0 = 1'b1; a0 = 16'h0001; v0 = 4'd1;
        s1 = 1'b1; a1 = 16'h0002; v1 = 4'd2;
        exp_q.push_back(mk(1'b0, 16'h0001, 4'd1));
        exp_q.push_back(mk(1'b1, 16'h0002, 4'd2));
        tick();
        s0 = 1'b0; s1 = 1'b0;
        repeat (8) tick();
        chk_spacing("rr_spacing", 2);
        s0 = 1'b1; a0 = 16'h0011; v0 = 4'd3;
        s1 = 1'b1; a1 = 16'h0012; v1 = 4'd4;
        exp_q.push_back(mk(1'b0, 16'h0011, 4'd3));
        exp_q.push_back(mk(1'b1, 16'h0012, 4'd4));
        tick();
        s0 = 1'b0; s1 = 1'b0;
        repeat (8) tick();

        // Holdoff with source 0 strobing every cycle: A0,A1,A4,A7 survive
        issue_cyc.delete();
        exp_q.push_back(mk(1'b0, 16'h0300, 4'd0));
        exp_q.push_back(mk(1'b0, 16'h0301, 4'd1));
        exp_q.push_back(mk(1'b0, 16'h0304, 4'd4));
        exp_q.push_back(mk(1'b0, 16'h0307, 4'd7));
        for (int i = 0; i < 10; i++) begin
            s0 = 1'b1; a0 = 16'h0300 + 16'(i); v0 = 4'(i);
            tick();
            @(negedge clk);
            chk($sformatf("holdoff_ovf0_%0d", i), 32'(ovf0), 32'(i >= 2));
            #1;
        end
        s0 = 1'b0;
        repeat (10) tick();
        chk_spacing("holdoff_spacing", 4);
        chk("holdoff_idle", 32'(idle), 32'd1);

        // Bypass refill on source 1
        ready = 1'b0;
        s1 = 1'b1; a1 = 16'h0909; v1 = 4'd9;
        tick();
        s1 = 1'b0;
        tick();
        ready = 1'b1;
        s1 = 1'b1; a1 = 16'h0A0B; v1 = 4'hA;
        exp_q.push_back(mk(1'b1, 16'h0909, 4'd9));
        exp_q.push_back(mk(1'b1, 16'h0A0B, 4'hA));
        tick();
        s1 = 1'b0;
        @(negedge clk);
        chk("bypass_req1_still_full", 32'(req1), 32'd0);
        repeat (6) tick();
        chk("bypass_ovf1", 32'(ovf1), 32'd0);
        chk("bypass_idle", 32'(idle), 32'd1);

        // Backpressure with both slots full (rr_ptr is 0 after a src1 issue)
        ready = 1'b0;
        s0 = 1'b1; a0 = 16'h0505; v0 = 4'd5;
        s1 = 1'b1; a1 = 16'h0606; v1 = 4'd6;
        tick();
        s0 = 1'b0; s1 = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_vld !== 1'b0) bad++;
            tick();
        end
        chk("bp_valid_pulses", 32'(bad), 32'd0);
        chk("bp_req0", 32'(req0), 32'd0);
        chk("bp_req1", 32'(req1), 32'd0);
        issue_cyc.delete();
        exp_q.push_back(mk(1'b0, 16'h0505, 4'd5));
        exp_q.push_back(mk(1'b1, 16'h0606, 4'd6));
        ready = 1'b1;
        repeat (10) tick();
        chk_spacing("bp_spacing", 2);

        // Reset during HOLDOFF with slot 1 still full
        s0 = 1'b1; a0 = 16'h0707; v0 = 4'd7;
        s1 = 1'b1; a1 = 16'h0808; v1 = 4'd8;
        exp_q.push_back(mk(1'b0, 16'h0707, 4'd7));
        tick();
        s0 = 1'b0; s1 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle", 32'(idle), 32'd1);
        chk("midrst_req0", 32'(req0), 32'd1);
        chk("midrst_req1", 32'(req1), 32'd1);
        chk("midrst_cnt0", 32'(cnt0), 32'd0);
        chk("midrst_cnt1", 32'(cnt1), 32'd0);
        chk("midrst_valid", 32'(o_vld), 32'd0);
        repeat (10) tick();

        // Counter saturation at CNT_WIDTH=4
        for (int i = 0; i < 18; i++) begin
            s0 = 1'b1; a0 = 16'h1000 + 16'(i); v0 = 4'(i);
            exp_q.push_back(mk(1'b0, 16'h1000 + 16'(i), 4'(i)));
            tick();
            s0 = 1'b0;
            repeat (3) tick();
            if (i == 14) chk("sat_cnt0_at_15", 32'(cnt0), 32'd15);
        end
        repeat (4) tick();
        chk("sat_cnt0_after_18", 32'(cnt0), 32'd15);
        chk("sat_cnt1", 32'(cnt1), 32'd0);
        chk("sat_ovf0", 32'(ovf0), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
